// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and load/store, with data priority and an anti-starvation limit.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a stuck transaction after TIMEOUT_CYCLES.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DSTREAK    = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_gnt,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_ready,
  input  logic                bus_rvalid,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                bus_err
);

  // state  | meaning
  // IDLE   | no transaction outstanding; arbitrate and present winner on the bus
  // WAIT_I | fetch accepted, waiting for its bus response
  // WAIT_D | load/store accepted, waiting for its bus response
  typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;

  state_t     state, state_nxt;
  logic [3:0] dstreak;
  logic       squash;
  logic       mem_win;
  logic       to_fire;
  logic       rsp_done;
  logic       fetch_done;
  logic       data_done;
  logic       squash_now;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;

  // Held at zero in IDLE so it starts from zero on every entry to WAIT_x.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (state == IDLE)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + 1'b1;
  end

  assign to_fire = (state != IDLE) && !bus_rvalid &&
                   (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      bus_err <= 1'b0;
    else
      bus_err <= to_fire;
  end
`else
  assign to_fire = 1'b0;
  assign bus_err = (TIMEOUT_CYCLES < 0);
`endif

  assign rsp_done   = bus_rvalid | to_fire;
  assign fetch_done = (state == WAIT_I) && rsp_done;
  assign data_done  = (state == WAIT_D) && rsp_done;
  assign squash_now = squash | if_flush;
  assign mem_win    = mem_req && !(if_req && (dstreak == 4'(MAX_DSTREAK)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (mem_gnt)
          state_nxt = WAIT_D;
        else if (if_gnt)
          state_nxt = WAIT_I;
      end
      WAIT_I, WAIT_D: begin
        if (rsp_done)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Gated by rst so every output reads 0 while reset is held, even with requests pending.
  always_comb begin
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_wstrb = '0;
    bus_addr  = '0;
    bus_wdata = '0;
    mem_gnt   = 1'b0;
    if_gnt    = 1'b0;
    if (!rst && state == IDLE) begin
      if (mem_win) begin
        bus_req   = 1'b1;
        bus_we    = mem_we;
        bus_wstrb = mem_wstrb;
        bus_addr  = mem_addr;
        bus_wdata = mem_wdata;
        mem_gnt   = bus_ready;
      end else if (if_req) begin
        bus_req  = 1'b1;
        bus_addr = if_addr;
        if_gnt   = bus_ready;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dstreak <= '0;
    else if (mem_gnt) begin
      if (!if_req)
        dstreak <= '0;
      else if (dstreak != 4'(MAX_DSTREAK))
        dstreak <= dstreak + 4'd1;
    end else if (if_gnt)
      dstreak <= '0;
  end

  // A flush in the grant cycle counts as well as one during WAIT_I.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      squash <= 1'b0;
    else if (state != IDLE && rsp_done)
      squash <= 1'b0;
    else if (if_flush && (if_gnt || state == WAIT_I))
      squash <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
    end else begin
      if_rvalid  <= fetch_done && !squash_now;
      mem_rvalid <= data_done;
      if (fetch_done && !squash_now)
        if_rdata <= bus_rvalid ? bus_rdata : '0;
      if (data_done)
        mem_rdata <= bus_rvalid ? bus_rdata : '0;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the watchdog step runs only when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        bus_req, bus_we, bus_ready, bus_rvalid, bus_err;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_wstrb = '0; mem_addr = '0; mem_wdata = '0;
    bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;
    #1;
    chk("rst_bus_req", bus_req, 0);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_if_rvalid", if_rvalid, 0);
    chk("rst_mem_rvalid", mem_rvalid, 0);
    chk("rst_bus_err", bus_err, 0);
    cyc(); cyc();

    // single fetch, response two cycles after grant
    cyc(); rst = 1'b0; #1;
    chk("f1_gnt", if_gnt, 1);
    chk("f1_mem_gnt", mem_gnt, 0);
    chk("f1_bus_req", bus_req, 1);
    chk("f1_bus_addr", bus_addr, 32'h100);
    chk("f1_bus_we", bus_we, 0);
    chk("f1_bus_wstrb", bus_wstrb, 0);
    chk("f1_bus_wdata", bus_wdata, 0);
    cyc(); if_req = 1'b0; #1;
    chk("f1_wait_bus_req", bus_req, 0);
    chk("f1_wait_rvalid", if_rvalid, 0);
    cyc(); bus_rvalid = 1'b1; bus_rdata = 32'h13; #1;
    chk("f1_rvalid_early", if_rvalid, 0);
    cyc(); bus_rvalid = 1'b0; #1;
    chk("f1_rvalid", if_rvalid, 1);
    chk("f1_rdata", if_rdata, 32'h13);

    // simultaneous requests: data first, fetch on return to IDLE
    cyc(); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; if_req = 1'b1; if_addr = 32'h104; #1;
    chk("f1_rvalid_pulse", if_rvalid, 0);
    chk("f1_rdata_hold", if_rdata, 32'h13);
    chk("both_mem_gnt", mem_gnt, 1);
    chk("both_if_gnt", if_gnt, 0);
    chk("both_bus_addr", bus_addr, 32'h200);
    cyc(); mem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hCAFE0001; #1;
    chk("both_waitd_if_gnt", if_gnt, 0);
    chk("both_waitd_bus_req", bus_req, 0);
    cyc(); bus_rvalid = 1'b0; #1;
    chk("both_mem_rvalid", mem_rvalid, 1);
    chk("both_mem_rdata", mem_rdata, 32'hCAFE0001);
    chk("both_if_gnt2", if_gnt, 1);
    chk("both_bus_addr2", bus_addr, 32'h104);
    cyc(); if_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h55; #1;
    chk("both_mem_rvalid_pulse", mem_rvalid, 0);
    cyc(); bus_rvalid = 1'b0; #1;
    chk("both_if_rvalid", if_rvalid, 1);
    chk("both_if_rdata", if_rdata, 32'h55);

    // continuous contention: D,D,D,D,I repeating
    for (int i = 0; i < 10; i++) begin
      cyc(); if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h77; #1;
      chk($sformatf("streak%0d_mem_gnt", i), mem_gnt, (i % 5) != 4);
      chk($sformatf("streak%0d_if_gnt", i), if_gnt, (i % 5) == 4);
      cyc();
    end
    cyc(); if_req = 1'b0; mem_req = 1'b0; bus_rvalid = 1'b0; #1;
    chk("streak_if_rvalid", if_rvalid, 1);
    chk("streak_if_rdata", if_rdata, 32'h77);

    // store, first held off by bus_ready=0
    cyc(); mem_req = 1'b1; mem_we = 1'b1; mem_wstrb = 4'b0011; mem_addr = 32'h300;
    mem_wdata = 32'hDEADBEEF; bus_ready = 1'b0; #1;
    chk("st_bus_req", bus_req, 1);
    chk("st_gnt_stall", mem_gnt, 0);
    chk("st_bus_we", bus_we, 1);
    chk("st_bus_wstrb", bus_wstrb, 4'b0011);
    chk("st_bus_wdata", bus_wdata, 32'hDEADBEEF);
    chk("st_bus_addr", bus_addr, 32'h300);
    cyc(); bus_ready = 1'b1; #1;
    chk("st_gnt", mem_gnt, 1);
    cyc(); mem_req = 1'b0; mem_we = 1'b0; mem_wstrb = '0; mem_wdata = '0;
    bus_rvalid = 1'b1; bus_rdata = 32'hA5A5A5A5; #1;
    chk("st_wait_bus_req", bus_req, 0);
    chk("st_ack_early", mem_rvalid, 0);
    cyc(); bus_rvalid = 1'b0; #1;
    chk("st_ack", mem_rvalid, 1);
    chk("st_rdata", mem_rdata, 32'hA5A5A5A5);
    cyc(); bus_rvalid = 1'b1; bus_rdata = 32'hFFFF0000; #1;
    chk("idle_rv_bus_req", bus_req, 0);
    cyc(); bus_rvalid = 1'b0; #1;
    chk("idle_rv_mem_rvalid", mem_rvalid, 0);
    chk("idle_rv_if_rvalid", if_rvalid, 0);
    chk("idle_rv_mem_rdata", mem_rdata, 32'hA5A5A5A5);

    // flush in WAIT_I squashes the response; next fetch is normal
    cyc(); if_req = 1'b1; if_addr = 32'h400; #1;
    chk("fl_gnt", if_gnt, 1);
    cyc(); if_req = 1'b0; if_flush = 1'b1;
    cyc(); if_flush = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBAD; #1;
    chk("fl_rvalid_early", if_rvalid, 0);
    cyc(); bus_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h404; #1;
    chk("fl_squashed", if_rvalid, 0);
    chk("fl_rdata_hold", if_rdata, 32'h77);
    chk("fl_next_gnt", if_gnt, 1);
    chk("fl_next_addr", bus_addr, 32'h404);
    cyc(); if_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h99;
    cyc(); bus_rvalid = 1'b0; #1;
    chk("fl_next_rvalid", if_rvalid, 1);
    chk("fl_next_rdata", if_rdata, 32'h99);

`ifdef ARB_TIMEOUT_EN
    // watchdog: no bus response for 8 WAIT_D cycles
    cyc(); mem_req = 1'b1; mem_addr = 32'h500; #1;
    chk("to_gnt", mem_gnt, 1);
    cyc(); mem_req = 1'b0; #1;
    chk("to_w1_rvalid", mem_rvalid, 0);
    chk("to_w1_err", bus_err, 0);
    for (int k = 2; k <= 8; k++) begin
      cyc(); #1;
      chk($sformatf("to_w%0d_rvalid", k), mem_rvalid, 0);
      chk($sformatf("to_w%0d_err", k), bus_err, 0);
    end
    cyc(); #1;
    chk("to_rvalid", mem_rvalid, 1);
    chk("to_rdata", mem_rdata, 0);
    chk("to_err", bus_err, 1);
    cyc(); #1;
    chk("to_err_pulse", bus_err, 0);
    chk("to_rvalid_pulse", mem_rvalid, 0);
`endif

    // reset while in WAIT_D, then a late bus response
    cyc(); mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h600; #1;
    chk("rw_gnt", mem_gnt, 1);
    cyc(); mem_req = 1'b0; if_req = 1'b1; rst = 1'b1; #1;
    chk("rw_bus_req", bus_req, 0);
    chk("rw_if_gnt", if_gnt, 0);
    chk("rw_mem_rdata", mem_rdata, 0);
    chk("rw_if_rdata", if_rdata, 0);
    chk("rw_mem_rvalid", mem_rvalid, 0);
    chk("rw_bus_err", bus_err, 0);
    cyc(); rst = 1'b0; if_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'h1234; #1;
    chk("rw_late_bus_req", bus_req, 0);
    cyc(); bus_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h700; #1;
    chk("rw_late_mem_rvalid", mem_rvalid, 0);
    chk("rw_late_mem_rdata", mem_rdata, 0);
    chk("rw_idle_if_gnt", if_gnt, 1);
    cyc(); if_req = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
